// File: rtl/par_nibble_collector.sv
// Consumer side of the 4-bit request/sample parallel interface: requests nibbles,
// packs NIBBLES of them into a word, checks +1 mod 16 sequencing, offers the word valid/ready.
module par_nibble_collector #(
  parameter int NIBBLES     = 4,
  parameter int REQ_CYCLES  = 1,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [3:0]                 data,
  output logic                       ask_for_data,
  output logic [4*NIBBLES-1:0]       word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(NIBBLES)-1:0] nib_cnt,
  output logic                       seq_err,
  output logic [7:0]                 err_count,
  output logic [2:0]                 dbg_state
);

  localparam int NW   = $clog2(NIBBLES);
  localparam int CMAX = (REQ_CYCLES > WAIT_CYCLES) ? REQ_CYCLES : WAIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] REQ_LAST  = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIBBLES - 1);

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("NIBBLES must be in 2..8");
  end
  if (REQ_CYCLES < 1) begin : g_bad_req
    $error("REQ_CYCLES must be >= 1");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NW-1:0]        nib_cnt_q, nib_cnt_d;
  logic [4*NIBBLES-1:0] partial_q, partial_d;
  logic [4*NIBBLES-1:0] word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 ask_q, ask_d;
  logic [3:0]           prev_q, prev_d;
  logic                 have_prev_q, have_prev_d;
  logic                 seq_err_q, seq_err_d;
  logic [7:0]           err_count_q, err_count_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    nib_cnt_d     = nib_cnt_q;
    partial_d     = partial_q;
    word_d        = word_q;
    word_valid_d  = word_valid_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    seq_err_d     = seq_err_q;
    err_count_d   = err_count_q;

    // Downstream consumption; an OUT reload below overrides this in the same cycle.
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = CAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAP: begin
        partial_d[4*nib_cnt_q +: 4] = data;
        if (have_prev_q && (data != (prev_q + 4'd1))) begin
          seq_err_d = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
        prev_d      = data;
        have_prev_d = 1'b1;
        cnt_d       = '0;
        if (nib_cnt_q == NIB_LAST) begin
          nib_cnt_d = '0;
          state_d   = OUT;
        end else begin
          nib_cnt_d = nib_cnt_q + 1'b1;
          state_d   = en ? REQ : IDLE;
        end
      end
      OUT: begin
        if (!word_valid_q || word_ready) begin
          word_d       = partial_d;
          word_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = en ? REQ : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered request strobe: high exactly while the next state is REQ.
    ask_d = (state_d == REQ);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nib_cnt_q    <= '0;
      partial_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      ask_q        <= 1'b0;
      prev_q       <= 4'd0;
      have_prev_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nib_cnt_q    <= nib_cnt_d;
      partial_q    <= partial_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      ask_q        <= ask_d;
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      seq_err_q    <= seq_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign ask_for_data = ask_q;
  assign word         = word_q;
  assign word_valid   = word_valid_q;
  assign nib_cnt      = nib_cnt_q;
  assign seq_err      = seq_err_q;
  assign err_count    = err_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_par_nibble_collector.sv
// Bench for par_nibble_collector: a source model answers each request with the next nibble,
// and a nibble-list reference model predicts words and sequencing errors.
module tb_par_nibble_collector;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  // Handshake: word moves downstream on a rising sclk edge where word_valid && word_ready.
  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   data = 4'd0;
  logic         word_ready = 1'b0;
  logic         ask_for_data;
  logic [W-1:0] word;
  logic         word_valid;
  logic [1:0]   nib_cnt;
  logic         seq_err;
  logic [7:0]   err_count;
  logic [2:0]   dbg_state;

  par_nibble_collector #(.NIBBLES(NIB), .REQ_CYCLES(1), .WAIT_CYCLES(2)) dut (
    .sclk(sclk), .rst(rst), .en(en), .data(data), .ask_for_data(ask_for_data),
    .word(word), .word_valid(word_valid), .word_ready(word_ready), .nib_cnt(nib_cnt),
    .seq_err(seq_err), .err_count(err_count), .dbg_state(dbg_state)
  );

  always #5 sclk = ~sclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: nibbles in the order the source handed them out.
  logic [W-1:0] exp_q[$];
  logic [3:0]   nib_q[$];
  logic [3:0]   m_prev;
  bit           m_have;
  int           m_err;

  function automatic void model_capture(input logic [3:0] v);
    logic [W-1:0] w;
    if (m_have && v != 4'(m_prev + 4'd1)) m_err++;
    m_prev = v;
    m_have = 1'b1;
    nib_q.push_back(v);
    if (nib_q.size() == NIB) begin
      w = '0;
      for (int i = 0; i < NIB; i++) w = w | (W'(nib_q[i]) << (4 * i));
      exp_q.push_back(w);
      nib_q.delete();
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    nib_q.delete();
    m_have = 1'b0;
    m_err  = 0;
  endfunction

  // Source model and edge bookkeeping, evaluated just after each rising edge.
  int         cyc = 0;
  int         req_total = 0;
  int         step_mode = 0;
  bit         jump_arm = 1'b0;
  logic [3:0] jump_val = 4'd0;
  bit         rnd_jump = 1'b0;
  logic       ask_prev = 1'b0;
  logic       wv_prev = 1'b0;
  logic [3:0] nv;
  int         rise_q[$];
  int         vrise_q[$];
  int         vfall_q[$];

  always @(posedge sclk) cyc++;

  always @(posedge sclk) begin
    #1;
    if (ask_for_data && !ask_prev) begin
      nv = data + 4'd1;
      if (step_mode == 2 || (jump_arm && data == jump_val) ||
          (rnd_jump && $urandom_range(0, 15) == 0)) begin
        nv = data + 4'd2;
        jump_arm = 1'b0;
      end
      data = nv;
      req_total++;
      rise_q.push_back(cyc);
      model_capture(nv);
    end
    ask_prev = ask_for_data;
    if (word_valid && !wv_prev) vrise_q.push_back(cyc);
    if (!word_valid && wv_prev) vfall_q.push_back(cyc);
    wv_prev = word_valid;
  end

  // Scoreboard: inputs are stable from posedge+2 through the next posedge.
  logic [W-1:0] acc_words[$];
  always @(negedge sclk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) check("word_unexpected", 32'(exp_q.size()), 32'd1);
      else check("word", 32'(word), 32'(exp_q.pop_front()));
      acc_words.push_back(word);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #2;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int t = 0;
    while (acc_words.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_acc_timeout", 32'(acc_words.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input int n, input int budget);
    int t = 0;
    while (req_total < n && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_req_timeout", 32'(req_total >= n), 32'd1);
  endtask

  task automatic do_reset(input logic [3:0] start, input bit en_on);
    rst = 1'b1;
    en  = en_on;
    model_clear();
    step_mode = 0;
    jump_arm  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 4'($urandom);
      @(posedge sclk);
      #1;
      check("rst_ask", 32'(ask_for_data), 32'd0);
      check("rst_word", 32'(word), 32'd0);
      check("rst_valid", 32'(word_valid), 32'd0);
      check("rst_nibcnt", 32'(nib_cnt), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      #1;
    end
    rst  = 1'b0;
    data = start;
    @(posedge sclk);
    #1;
    check("post_rst_word", 32'(word), 32'd0);
    check("post_rst_valid", 32'(word_valid), 32'd0);
    check("post_rst_seq_err", 32'(seq_err), 32'd0);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    #1;
  endtask

  int a0, r0, l0;
  logic [3:0]   d0;
  logic [W-1:0] w_exp;

  initial begin
    tick(1);
    // Reset with en high and data toggling
    do_reset(4'h0, 1'b1);

    // Normal run: latency, request cadence, first two words
    en = 1'b0;
    tick(2);
    do_reset(4'h0, 1'b0);
    word_ready = 1'b1;
    a0 = acc_words.size();
    l0 = rise_q.size();
    vrise_q.delete();
    vfall_q.delete();
    en = 1'b1;
    wait_acc(a0 + 2, 100);
    check("latency", 32'(vrise_q[0] - rise_q[l0]), 32'd17);
    check("nib_period_a", 32'(rise_q[l0+1] - rise_q[l0]), 32'd4);
    check("nib_period_b", 32'(rise_q[l0+3] - rise_q[l0+2]), 32'd4);
    check("word_boundary_gap", 32'(rise_q[l0+4] - rise_q[l0+3]), 32'd5);
    check("valid_one_cycle", 32'(vfall_q[0] - vrise_q[0]), 32'd1);
    check("word0_normal", 32'(acc_words[a0]), 32'h4321);
    check("word1_normal", 32'(acc_words[a0+1]), 32'h8765);
    check("seq_err_normal", 32'(seq_err), 32'd0);
    en = 1'b0;
    tick(10);

    // Backpressure
    do_reset(4'h0, 1'b0);
    word_ready = 1'b0;
    r0 = req_total;
    en = 1'b1;
    tick(60);
    check("bp_req_count", 32'(req_total - r0), 32'd8);
    check("bp_word_held", 32'(word), 32'h4321);
    check("bp_valid_held", 32'(word_valid), 32'd1);
    check("bp_ask_idle", 32'(ask_for_data), 32'd0);
    word_ready = 1'b1;
    @(posedge sclk);
    #2;
    check("bp_word_next", 32'(word), 32'h8765);
    check("bp_valid_next", 32'(word_valid), 32'd1);
    check("bp_req_resume", 32'(req_total - r0), 32'd9);
    en = 1'b0;
    tick(20);

    // Sequence error 3 -> 5
    do_reset(4'h0, 1'b0);
    jump_arm = 1'b1;
    jump_val = 4'h3;
    a0 = acc_words.size();
    en = 1'b1;
    wait_acc(a0 + 2, 100);
    en = 1'b0;
    tick(10);
    check("err_word0", 32'(acc_words[a0]), 32'h5321);
    check("err_word1", 32'(acc_words[a0+1]), 32'h9876);
    check("err_seq_err", 32'(seq_err), 32'd1);
    check("err_count_one", 32'(err_count), 32'd1);
    check("err_count_model", 32'(err_count), 32'(m_err));

    // Wrap F -> 0 is legal
    do_reset(4'hD, 1'b0);
    a0 = acc_words.size();
    en = 1'b1;
    wait_acc(a0 + 1, 60);
    en = 1'b0;
    tick(10);
    check("wrap_word", 32'(acc_words[a0]), 32'h10FE);
    check("wrap_seq_err", 32'(seq_err), 32'd0);

    // Saturation after 300 violations
    step_mode = 2;
    r0 = req_total;
    en = 1'b1;
    wait_req(r0 + 300, 2000);
    en = 1'b0;
    step_mode = 0;
    tick(12);
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_model", 32'(err_count), 32'((m_err > 255) ? 255 : m_err));
    check("sat_seq_err", 32'(seq_err), 32'd1);

    // en dropped mid-word, then resumed
    do_reset(4'h0, 1'b0);
    r0 = req_total;
    a0 = acc_words.size();
    en = 1'b1;
    wait_req(r0 + 2, 40);
    en = 1'b0;
    tick(10);
    check("en_nib_cnt", 32'(nib_cnt), 32'd2);
    check("en_req_held", 32'(req_total - r0), 32'd2);
    check("en_ask_idle", 32'(ask_for_data), 32'd0);
    en = 1'b1;
    wait_acc(a0 + 1, 60);
    en = 1'b0;
    tick(20);
    check("en_resume_word", 32'(acc_words[a0]), 32'h4321);

    // Reset mid-word discards the partial word
    r0 = req_total;
    en = 1'b1;
    wait_req(r0 + 2, 40);
    en = 1'b0;
    tick(10);
    d0 = data;
    do_reset(d0, 1'b0);
    check("rst_mid_nib_cnt", 32'(nib_cnt), 32'd0);
    w_exp = {4'(d0 + 4'd4), 4'(d0 + 4'd3), 4'(d0 + 4'd2), 4'(d0 + 4'd1)};
    a0 = acc_words.size();
    en = 1'b1;
    wait_acc(a0 + 1, 60);
    en = 1'b0;
    tick(20);
    check("rst_mid_fresh_word", 32'(acc_words[a0]), 32'(w_exp));
    check("rst_mid_seq_err", 32'(seq_err), 32'd0);

    // Randomized en / backpressure / occasional skips
    do_reset(4'($urandom), 1'b0);
    rnd_jump = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      word_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    rnd_jump = 1'b0;
    en = 1'b0;
    word_ready = 1'b1;
    tick(40);
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_nib_cnt", 32'(nib_cnt), 32'(nib_q.size()));
    check("rnd_seq_err", 32'(seq_err), 32'(m_err != 0));
    check("rnd_err_count", 32'(err_count), 32'((m_err > 255) ? 255 : m_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/par_nibble_collector.md
Name: par_nibble_collector

Overview:
- Consumer end of the 4-bit parallel-data request interface.
- Pulses ask_for_data to request each nibble, waits for the source to update, then samples data.
- Packs NIBBLES consecutive nibbles into one word and offers it downstream with a valid/ready handshake.
- Checks that successive nibbles increment by 1 modulo 16 and reports violations.

Parameters:
NIBBLES, 4, nibbles packed per output word (2..8)
REQ_CYCLES, 1, sclk cycles ask_for_data is held high per request (>=1)
WAIT_CYCLES, 2, sclk cycles between ask_for_data falling and sampling data (>=1)

Ports:
sclk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  allow new requests; when low, no new request is started
data  input  4  parallel nibble from the source
ask_for_data  output  1  request pulse; the source advances data on its rising edge
word  output  4*NIBBLES  assembled word; first-captured nibble in bits [3:0]
word_valid  output  1  word holds an unconsumed value
word_ready  input  1  downstream accepts word when word_valid && word_ready
nib_cnt  output  clog2(NIBBLES)  nibbles captured in the current partial word
seq_err  output  1  sticky; set on the first increment violation
err_count  output  8  count of increment violations, saturates at 255

Behaviour:
- Interface: one clock, sclk. Reset is synchronous and active-high on rst, sampled on the sclk rising edge.
- Reset values:
  - ask_for_data=0, word=0, word_valid=0, nib_cnt=0, seq_err=0, err_count=0.
  - Partial word cleared, have_prev=0, state=IDLE.
  - Reset asserted mid-operation discards everything, including a partial word and an unconsumed word.
- State IDLE: if en=1, go to REQ next cycle. Otherwise stay in IDLE.
- State REQ:
  - ask_for_data=1 for exactly REQ_CYCLES cycles, registered output.
  - Then go to WAIT. en is ignored once REQ is entered.
- State WAIT:
  - ask_for_data=0 for exactly WAIT_CYCLES cycles, then go to CAP.
  - This guarantees a low gap, so every request is a fresh rising edge.
- State CAP (1 cycle):
  - Sample data into partial[4*nib_cnt +: 4].
  - If have_prev=1 and data != prev+1 (mod 16): set seq_err=1 and increment err_count, saturating at 255.
  - prev<=data; have_prev<=1. 0xF followed by 0x0 is legal.
  - If nib_cnt==NIBBLES-1: go to OUT with nib_cnt<=0.
  - Otherwise nib_cnt<=nib_cnt+1, then go to REQ if en=1, else IDLE. The partial word is retained and collection resumes when en returns.
- State OUT:
  - If word_valid==0, or word_ready==1 this cycle: word<=partial, word_valid<=1, then go to REQ if en=1, else IDLE.
  - Otherwise stall in OUT with ask_for_data=0.
- Output register: word_valid clears on a cycle with word_valid && word_ready, unless OUT reloads it in the same cycle, in which case it stays 1 with the new word. word is stable while word_valid=1 and word_ready=0.
- Nibble period: REQ_CYCLES+WAIT_CYCLES+1 cycles (4 with defaults).
- Unstalled word latency: NIBBLES*(nibble period)+1 cycles from the first REQ to word_valid (17 with defaults).
- seq_err and err_count clear only on rst. have_prev persists across words.
- Implementations must statically reject parameter values outside the stated ranges.

Test Plan:
1. Reset: rst=1 for 3 cycles with en=1 and data toggling -> ask_for_data stays 0; word=0, word_valid=0, seq_err=0, err_count=0 throughout and one cycle after release.
2. Normal run: source model starts at data=0 and increments within one cycle of each ask_for_data rising edge; en=1, word_ready=1, defaults.
   - ask_for_data high every 4th cycle.
   - First word=16'h4321 with word_valid high 1 cycle, 17 cycles after the first REQ.
   - Second word=16'h8765; seq_err=0.
3. Backpressure: word_ready=0 from start.
   - word=16'h4321 held with word_valid=1.
   - The second word's four requests still occur, then ask_for_data stays 0 in OUT.
   - Raise word_ready -> word=16'h8765 on the next edge and requests resume.
4. Sequence error: source jumps 3->5 -> seq_err=1 and err_count=1 after that CAP; word=16'h5321 still delivered; later correct increments leave err_count=1.
5. Wrap and saturation:
   - Data ...E,F,0,1 -> word=16'h10FE, no error.
   - Forced 300 violations -> err_count=255.
6. en/reset mid-word:
   - Drop en after 2 nibbles -> nib_cnt=2 and ask_for_data idle; re-raise en -> remaining 2 nibbles complete a correct word.
   - Assert rst after 2 nibbles -> nib_cnt=0, and the next word is built from 4 fresh nibbles.
